// File: rtl/ysyx_22041071_div_64_pkg.sv
// rtl/ysyx_22041071_div_64_pkg.sv - shared widths, state encoding and helpers for the divider
package ysyx_22041071_div_64_pkg;

  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] ysyx_22041071_data_bus_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam ysyx_22041071_data_bus_t DIV_ZERO_Q = '1;

  function automatic ysyx_22041071_data_bus_t w_sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22041071_div_64_if.sv
// rtl/ysyx_22041071_div_64_if.sv - EX-stage request/result bundle for the divider
interface ysyx_22041071_div_64_if;
  import ysyx_22041071_div_64_pkg::*;

  logic                    flush;
  logic                    div_valid;
  logic                    div_signed;
  logic                    divw;
  ysyx_22041071_data_bus_t dividend;
  ysyx_22041071_data_bus_t divisor;
  logic                    div_ready;
  logic                    out_valid;
  ysyx_22041071_data_bus_t quotient;
  ysyx_22041071_data_bus_t remainder;

  modport master (
    output flush, div_valid, div_signed, divw, dividend, divisor,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  flush, div_valid, div_signed, divw, dividend, divisor,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22041071_div_prep.sv
// rtl/ysyx_22041071_div_prep.sv - operand conditioning: magnitudes, sign flags, zero/overflow results
module ysyx_22041071_div_prep
  import ysyx_22041071_div_64_pkg::*;
(
  input  ysyx_22041071_data_bus_t dividend,
  input  ysyx_22041071_data_bus_t divisor,
  input  logic                    div_signed,
  input  logic                    divw,
  output ysyx_22041071_data_bus_t dvd_abs,
  output ysyx_22041071_data_bus_t dvs_abs,
  output logic                    q_neg,
  output logic                    r_neg,
  output logic                    div_zero,
  output logic                    overflow,
  output ysyx_22041071_data_bus_t spec_q,
  output ysyx_22041071_data_bus_t spec_r
);

  ysyx_22041071_data_bus_t dvd_w, dvs_w, dvd_n, dvs_n, dvd_ext;
  logic dvd_sign, dvs_sign, dvd_min, dvs_m1;

  always_comb begin
    dvd_w    = divw ? {32'b0, dividend[31:0]} : dividend;
    dvs_w    = divw ? {32'b0, divisor[31:0]}  : divisor;
    dvd_sign = div_signed & (divw ? dividend[31] : dividend[XLEN-1]);
    dvs_sign = div_signed & (divw ? divisor[31]  : divisor[XLEN-1]);
    dvd_n    = -dvd_w;
    dvs_n    = -dvs_w;
    // W-mode magnitudes are kept to 32 bits so the iteration sees a clean zero-extended value
    dvd_abs  = dvd_sign ? (divw ? {32'b0, dvd_n[31:0]} : dvd_n) : dvd_w;
    dvs_abs  = dvs_sign ? (divw ? {32'b0, dvs_n[31:0]} : dvs_n) : dvs_w;
    q_neg    = dvd_sign ^ dvs_sign;
    r_neg    = dvd_sign;

    div_zero = (dvs_w == '0);
    dvd_min  = divw ? (dividend[31:0] == 32'h8000_0000)
                    : (dividend == {1'b1, {(XLEN-1){1'b0}}});
    dvs_m1   = divw ? (&divisor[31:0]) : (&divisor);
    overflow = div_signed & dvd_min & dvs_m1;

    dvd_ext  = divw ? w_sext(dividend[31:0]) : dividend;
    spec_q   = div_zero ? DIV_ZERO_Q : dvd_ext;
    spec_r   = div_zero ? dvd_ext : '0;
  end

endmodule

// File: rtl/ysyx_22041071_div_64.sv
// rtl/ysyx_22041071_div_64.sv - iterative radix-2 restoring divider for RV64M DIV/REM[U][W]
module ysyx_22041071_div_64
  import ysyx_22041071_div_64_pkg::*;
(
  input logic               clk,
  input logic               reset,
  ysyx_22041071_div_64_if.slave bus
);

  div_state_e              state_q;
  logic [5:0]              cnt_q;
  ysyx_22041071_data_bus_t rem_q, dvd_q, dvs_q;
  ysyx_22041071_data_bus_t quotient_q, remainder_q;
  logic                    q_neg_q, r_neg_q, w_q, out_valid_q;

  ysyx_22041071_data_bus_t dvd_abs, dvs_abs, spec_q, spec_r;
  logic                    q_neg, r_neg, div_zero, overflow;

  ysyx_22041071_div_prep u_prep (
    .dividend   (bus.dividend),
    .divisor    (bus.divisor),
    .div_signed (bus.div_signed),
    .divw       (bus.divw),
    .dvd_abs    (dvd_abs),
    .dvs_abs    (dvs_abs),
    .q_neg      (q_neg),
    .r_neg      (r_neg),
    .div_zero   (div_zero),
    .overflow   (overflow),
    .spec_q     (spec_q),
    .spec_r     (spec_r)
  );

  logic [XLEN:0]           shifted, trial;
  logic                    q_bit, last;
  ysyx_22041071_data_bus_t rem_d, dvd_d, q_mag, r_mag, q_fix, r_fix;

  // dvd_q doubles as the quotient: dividend bits leave at the top, quotient bits enter at the bottom
  always_comb begin
    shifted = {rem_q, dvd_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    q_bit   = ~trial[XLEN];
    rem_d   = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    dvd_d   = {dvd_q[XLEN-2:0], q_bit};
    q_mag   = q_neg_q ? -dvd_d : dvd_d;
    r_mag   = r_neg_q ? -rem_d : rem_d;
    q_fix   = w_q ? w_sext(q_mag[31:0]) : q_mag;
    r_fix   = w_q ? w_sext(r_mag[31:0]) : r_mag;
    last    = (cnt_q == (w_q ? 6'd31 : 6'd63));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      w_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.flush) begin
        state_q <= DIV_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          DIV_IDLE: begin
            if (bus.div_valid) begin
              w_q     <= bus.divw;
              q_neg_q <= q_neg;
              r_neg_q <= r_neg;
              // W operands sit in the top half so the MSB-first shift starts at bit 31
              dvd_q   <= bus.divw ? {dvd_abs[31:0], 32'b0} : dvd_abs;
              dvs_q   <= dvs_abs;
              rem_q   <= '0;
              cnt_q   <= '0;
              if (div_zero || overflow) begin
                quotient_q  <= spec_q;
                remainder_q <= spec_r;
                out_valid_q <= 1'b1;
                state_q     <= DIV_DONE;
              end else begin
                state_q <= DIV_BUSY;
              end
            end
          end
          DIV_BUSY: begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 6'd1;
            if (last) begin
              quotient_q  <= q_fix;
              remainder_q <= r_fix;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= DIV_DONE;
            end
          end
          DIV_DONE: state_q <= DIV_IDLE;
          default:  state_q <= DIV_IDLE;
        endcase
      end
    end
  end

  assign bus.div_ready = (state_q == DIV_IDLE);
  assign bus.out_valid = out_valid_q & ~bus.flush;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22041071_div_64.sv
// tb/tb_ysyx_22041071_div_64.sv - directed-vector bench for the 64-bit divider
module tb_ysyx_22041071_div_64;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  ysyx_22041071_div_64_if bus ();

  ysyx_22041071_div_64 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  task automatic start_op(input logic sgn, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.div_valid  = 1'b1;
    bus.div_signed = sgn;
    bus.divw       = w;
    bus.dividend   = a;
    bus.divisor    = b;
    @(posedge clk);
    #1;
    bus.div_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input int elat);
    int   c;
    int   ready_hi;
    logic seen;
    start_op(sgn, w, a, b);
    c = 1;
    ready_hi = 0;
    seen = 1'b0;
    while (c <= 100 && !seen) begin
      if (bus.out_valid) seen = 1'b1;
      else begin
        if (bus.div_ready) ready_hi++;
        @(posedge clk);
        #1;
        c++;
      end
    end
    check({tag, "_lat"}, 64'(c), 64'(elat));
    check({tag, "_ready_busy"}, 64'(ready_hi), 64'd0);
    check({tag, "_ready_done"}, {63'b0, bus.div_ready}, 64'd0);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    @(posedge clk);
    #1;
    check({tag, "_pulse_end"}, {63'b0, bus.out_valid}, 64'd0);
    check({tag, "_ready_idle"}, {63'b0, bus.div_ready}, 64'd1);
  endtask

  initial begin
    int seen_ov;
    n_pass = 0;
    n_total = 0;
    bus.flush = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_signed = 1'b0;
    bus.divw = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", bus.quotient, 64'd0);
    check("rst_r", bus.remainder, 64'd0);
    check("rst_ov", {63'b0, bus.out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", {63'b0, bus.div_ready}, 64'd1);

    run_op("div_neg7_2",  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu_max_16", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
           64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 65);
    run_op("divu_100_7",  1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    run_op("div_7_neg2",  1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_op("div_42_0",    1'b1, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1);
    run_op("divuw_by0",   1'b0, 1'b1, 64'h8000_0000, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("div_ovf",     1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 1);
    run_op("divw_ovf",    1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 64'd0, 1);
    run_op("divuw_1",     1'b0, 1'b1, 64'h8000_0000, 64'd1,
           64'hFFFF_FFFF_8000_0000, 64'd0, 33);
    run_op("remw_neg7_2", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // flush in BUSY cycle 10: no pulse, previous results held
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_ready", {63'b0, bus.div_ready}, 64'd1);
    seen_ov = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.out_valid) seen_ov++;
      @(posedge clk);
      #1;
    end
    check("flush_no_pulse", 64'(seen_ov), 64'd0);
    check("flush_q_held", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    check("flush_r_held", bus.remainder, 64'hFFFF_FFFF_FFFF_FFFF);

    // valid together with flush is not accepted
    @(negedge clk);
    bus.div_valid = 1'b1;
    bus.flush = 1'b1;
    bus.div_signed = 1'b0;
    bus.divw = 1'b0;
    bus.dividend = 64'd5;
    bus.divisor = 64'd0;
    @(posedge clk);
    #1;
    bus.div_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_valid_ready", {63'b0, bus.div_ready}, 64'd1);
    check("flush_valid_q", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFD);

    // asynchronous reset mid-BUSY clears outputs without a clock edge
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check("arst_q", bus.quotient, 64'd0);
    check("arst_r", bus.remainder, 64'd0);
    check("arst_ov", {63'b0, bus.out_valid}, 64'd0);
    check("arst_ready", {63'b0, bus.div_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    run_op("post_rst", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_div_64.md
Name: ysyx_22041071_div_64

Overview:
Iterative radix-2 restoring divider for the RV64M divide group: DIV, DIVU, REM and REMU, plus the W variants. It is the counterpart of the 64-bit shift-add multiplier and sits beside it in the EX stage. It uses the same valid/ready/flush handshake, so the EX control logic drives both units the same way. Both quotient and remainder are produced on every operation; EX selects the one it needs.

Parameters:
XLEN, 64, datapath width. Only 64 is supported; W mode divides the low 32 bits.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
flush  in  1  cancels any pending or in-flight operation
div_valid  in  1  request valid; accepted when div_ready=1 and flush=0
div_signed  in  1  1 selects signed (DIV/REM[W]), 0 selects unsigned (DIVU/REMU[W])
divw  in  1  32-bit operation on bits [31:0]
dividend  in  XLEN  numerator
divisor  in  XLEN  denominator
div_ready  out  1  high only in IDLE
out_valid  out  1  one-cycle pulse; results are valid in that cycle
quotient  out  XLEN  registered quotient
remainder  out  XLEN  registered remainder

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; counter, quotient, remainder, all internal registers and out_valid are 0. div_ready becomes 1 once reset deasserts. Reset in mid-operation aborts with no pulse.
- States:
  - IDLE: on accept, latch the conditioned operands and go to BUSY. If the divisor is zero or the operation is signed overflow, go to DONE instead.
  - BUSY: one iteration per cycle. counter runs 0..N-1, with N=64 (divw=0) or N=32 (divw=1). Go to DONE when counter==N-1.
  - DONE: out_valid=1, quotient and remainder written; go to IDLE next cycle.
- Latency: the accept cycle is cycle 0. out_valid is high in cycle N+1, which is 65 for 64-bit and 33 for W. Special cases give out_valid in cycle 1.
- quotient and remainder are updated only on entry to DONE. They are held stable until the next DONE; a new accept does not disturb them.
- Operand conditioning:
  - W mode uses bits [31:0]; the sign bit is bit 31.
  - Signed mode takes absolute values. Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
- Iteration:
  - The partial remainder is XLEN+1 bits. Shift it left by one, bringing in the next dividend MSB.
  - Trial-subtract |divisor|. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the quotient bit to 0.
- Final fixup:
  - Negate the quotient if q_neg; negate the remainder if r_neg.
  - In W mode both results are sign-extended from bit 31. This applies to DIVUW/REMUW as well, per the ISA.
- Divide by zero: quotient = all ones (all ones at 32 bits, then sign-extended, in W mode); remainder = dividend (sign-extended from bit 31 in W mode).
- Signed overflow (most-negative / -1, at 64 bits or at 32 bits in W mode): quotient = dividend (sign-extended in W mode); remainder = 0.
- Flush:
  - flush=1 in any state forces IDLE on the next edge and clears counter. out_valid is suppressed in that cycle even if the state is DONE.
  - div_valid together with flush is not accepted.
  - The quotient and remainder outputs keep their previous values.
- div_valid while not IDLE is ignored. There is no queueing, and no out_ready back-pressure: the consumer must capture results in the out_valid cycle or read the held outputs later.

Decomposition:
- Shared define.v gets:
  - ysyx_22041071_DATA_BUS
  - state encodings DIV_IDLE, DIV_BUSY, DIV_DONE
  - DIV_ZERO_Q (all ones)
  - W_SEXT helper macro
- One natural combinational sub-module: ysyx_22041071_div_prep (absolute values, sign flags, zero/overflow detect). Everything else stays in the top module.

Test Plan:
- Signed 64: -7 / 2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF; out_valid only in cycle 65; div_ready low in cycles 1..65.
- Unsigned 64: 0xFFFFFFFFFFFFFFFF / 0x10 -> quotient=0x0FFFFFFFFFFFFFFF, remainder=0xF.
- Divide by zero, signed: 42 / 0 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=42, out_valid in cycle 1. DIVUW 0x80000000 / 0 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=0xFFFFFFFF80000000.
- Overflow: signed 0x8000000000000000 / -1 -> quotient=0x8000000000000000, remainder=0. DIVW 0x80000000 / 0xFFFFFFFF -> quotient=0xFFFFFFFF80000000, remainder=0.
- W mode: DIVUW 0x80000000 / 1 -> quotient=0xFFFFFFFF80000000, out_valid in cycle 33. REMW -7 / 2 -> remainder=0xFFFFFFFFFFFFFFFF.
- Flush and reset:
  - Flush at BUSY cycle 10 -> no out_valid; div_ready=1 next cycle; prior results unchanged.
  - reset low mid-BUSY -> outputs 0 immediately without waiting for clk.
  - A back-to-back request after DONE is accepted in the following IDLE cycle.
